gcd_scheduler: RTL and testbench
================================

Name: gcd_scheduler

Overview:
- Shares one subtractive GCD engine among NREQ requesters using round-robin arbitration.
- Accepts operand pairs over valid/ready, sequences the engine with a start/done handshake, and returns each result to its requester.
- Handles zero operands locally without invoking the engine.
- Sits between client blocks and the single GCD datapath instance.

Parameters:
NREQ, 4, number of requesters (2..8)
W, 32, operand/result width
TIMEOUT, 1024, engine watchdog limit in cycles (used only with GCD_TIMEOUT_EN)

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-low
req_valid  input  NREQ  per-requester request valid
req_ready  output  NREQ  per-requester accept, one-hot or zero
req_a  input  NREQ*W  operand A, requester i at bits [i*W +: W]
req_b  input  NREQ*W  operand B, same packing as req_a
rsp_valid  output  NREQ  one-hot, one-cycle response strobe
rsp_data  output  W  result, valid when any rsp_valid bit is set
rsp_err  output  1  error flag qualifying rsp_valid (timeout)
busy  output  1  high in every state except IDLE
eng_start  output  1  one-cycle engine start pulse
eng_a  output  W  engine operand A, held stable from LAUNCH through WAIT
eng_b  output  W  engine operand B, held stable from LAUNCH through WAIT
eng_done  input  1  engine completion strobe
eng_result  input  W  engine result, sampled when eng_done=1 in WAIT

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, last_grant=NREQ-1.
  - req_ready, rsp_valid, rsp_data, rsp_err, busy, eng_start, eng_a, eng_b, and the internal operand/result registers all 0.
  - Reset asserted mid-operation drops eng_start and rsp_valid immediately and discards the in-flight request; no response is issued for it.
- States: IDLE, LAUNCH, WAIT, RESPOND.
- IDLE:
  - Winner = first index with req_valid=1, searching from (last_grant+1) mod NREQ upward and wrapping.
  - req_ready[winner]=1 combinationally; all other bits 0. req_ready is all-zero when no request is valid or the state is not IDLE.
  - On a transfer edge (valid&ready): latch gnt=winner, a, b.
  - If a==0 or b==0: result=a|b (so gcd(0,0)=0) and next state is RESPOND (bypass).
  - Otherwise next state is LAUNCH.
- Requesters hold req_valid and operands stable until ready. Dropping valid before ready is a legal withdrawal; the winner is recomputed every cycle while in IDLE.
- LAUNCH: eng_start=1 for exactly one cycle, eng_a/eng_b driven from the latched a/b. Next state is WAIT.
- WAIT:
  - eng_done is sampled only in this state; eng_done in any other state is ignored.
  - On eng_done=1: result<=eng_result, next state RESPOND.
- RESPOND:
  - rsp_valid[gnt]=1 and rsp_data=result for one cycle; no backpressure.
  - last_grant<=gnt, next state IDLE.
  - rsp_valid is a registered output; rsp_data holds its value until the next response.
- Latency, with the accept edge as cycle 0:
  - Bypass: rsp_valid in cycle 1.
  - Engine path: eng_start in cycle 1; eng_done sampled in cycle k (k>=2) gives rsp_valid in cycle k+1.
- New requests are accepted only in IDLE, so the earliest back-to-back accept is the cycle after RESPOND.
- Fairness: any continuously valid requester is granted within NREQ grants.

Optional Feature:
- Macro: GCD_TIMEOUT_EN.
- Defined:
  - A cycle counter clears on entry to WAIT and increments each WAIT cycle.
  - If the counter reaches TIMEOUT with no eng_done: next state RESPOND with rsp_data=0, rsp_err=1.
  - If eng_done and the timeout occur in the same cycle, eng_done wins and rsp_err=0.
  - rsp_err is otherwise 0 and is meaningful only with rsp_valid.
- Undefined: no counter, WAIT persists until eng_done, rsp_err tied to 0.

Test Plan:
- Single request, engine path: req 0 sends a=48, b=18; engine model asserts done with 6 after 10 cycles → req_ready[0] for one cycle, eng_start one cycle later with eng_a=48/eng_b=18, rsp_valid=4'b0001 with rsp_data=6 one cycle after done.
- Zero bypass: req 2 sends (0,35), then (0,0) → rsp_data=35, then 0, each one cycle after accept; eng_start never asserts.
- Round-robin: all four requesters hold valid continuously, each with (12,8) → grant order 0,1,2,3,0; every response has rsp_data=4 and is routed to the correct rsp_valid bit.
- Reset mid-WAIT: assert rst=0 two cycles after eng_start → outputs 0 immediately, no rsp_valid; after release, requester 0 is granted first.
- Stray done and withdrawal: eng_done=1 in IDLE is ignored; req 1 drops valid before ready while req 3 is valid → req 3 granted.
- GCD_TIMEOUT_EN defined, TIMEOUT=16, engine never asserts done → rsp_valid with rsp_err=1 and rsp_data=0 exactly 16 WAIT cycles after entry, then return to IDLE.

Source files
------------

// File: rtl/gcd_scheduler_if.sv
// Requester and engine signal bundle for gcd_scheduler.
// slave is the scheduler's view; master is the view of the clients and the engine.
interface gcd_scheduler_if #(
  parameter int NREQ = 4,
  parameter int W    = 32
);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ-1:0]   rsp_valid;
  logic [W-1:0]      rsp_data;
  logic              rsp_err;
  logic              busy;
  logic              eng_start;
  logic [W-1:0]      eng_a;
  logic [W-1:0]      eng_b;
  logic              eng_done;
  logic [W-1:0]      eng_result;

  modport slave (
    input  req_valid, req_a, req_b, eng_done, eng_result,
    output req_ready, rsp_valid, rsp_data, rsp_err, busy, eng_start, eng_a, eng_b
  );

  modport master (
    output req_valid, req_a, req_b, eng_done, eng_result,
    input  req_ready, rsp_valid, rsp_data, rsp_err, busy, eng_start, eng_a, eng_b
  );
endinterface

// File: rtl/gcd_scheduler.sv
// Round-robin scheduler sharing one subtractive GCD engine among NREQ requesters.
// Optional engine watchdog is enabled by defining GCD_TIMEOUT_EN.
module gcd_scheduler #(
  parameter int NREQ    = 4,
  parameter int W       = 32,
  parameter int TIMEOUT = 1024
) (
  input logic            clk,
  input logic            rst,
  gcd_scheduler_if.slave bus
);
  localparam int              GW       = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [GW:0]     NREQ_L   = (GW+1)'(NREQ);
  localparam logic [GW-1:0]   LAST_RST = GW'(NREQ - 1);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RESPOND} state_t;

  state_t          state;
  state_t          state_nx;
  logic [GW-1:0]   last_grant;
  logic [GW-1:0]   gnt;
  logic [GW-1:0]   win;
  logic            win_found;
  logic [W-1:0]    in_a;
  logic [W-1:0]    in_b;
  logic [W-1:0]    op_a;
  logic [W-1:0]    op_b;
  logic [NREQ-1:0] win_onehot;
  logic            timeout;
  logic            rsp_fire;
  logic            rsp_err_nx;
  logic [GW-1:0]   rsp_gnt;
  logic [W-1:0]    rsp_val;

  // Search starts just after the last granted requester and wraps.
  always_comb begin
    logic [GW:0] idx;
    idx       = '0;
    win       = last_grant;
    win_found = 1'b0;
    for (int off = 1; off <= NREQ; off++) begin
      idx = {1'b0, last_grant} + (GW+1)'(off);
      if (idx >= NREQ_L) idx = idx - NREQ_L;
      if (!win_found && bus.req_valid[idx[GW-1:0]]) begin
        win_found = 1'b1;
        win       = idx[GW-1:0];
      end
    end
  end

  always_comb begin
    in_a = '0;
    in_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win == GW'(i)) begin
        in_a = bus.req_a[i*W +: W];
        in_b = bus.req_b[i*W +: W];
      end
    end
  end

  assign win_onehot    = NREQ'(1) << win;
  assign bus.req_ready = (rst && state == IDLE && win_found) ? win_onehot : '0;
  assign bus.busy      = (state != IDLE);
  assign bus.eng_a     = op_a;
  assign bus.eng_b     = op_b;

  // Zero operands short-circuit straight to RESPOND with a|b.
  always_comb begin
    state_nx   = state;
    rsp_gnt    = gnt;
    rsp_val    = '0;
    rsp_err_nx = 1'b0;
    case (state)
      IDLE: begin
        if (win_found) begin
          rsp_gnt  = win;
          rsp_val  = in_a | in_b;
          state_nx = (in_a == '0 || in_b == '0) ? RESPOND : LAUNCH;
        end
      end
      LAUNCH:  state_nx = WAIT;
      WAIT: begin
        if (bus.eng_done) begin
          rsp_val  = bus.eng_result;
          state_nx = RESPOND;
        end else if (timeout) begin
          rsp_err_nx = 1'b1;
          state_nx   = RESPOND;
        end
      end
      RESPOND: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign rsp_fire = (state_nx == RESPOND) && (state != RESPOND);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      last_grant    <= LAST_RST;
      gnt           <= '0;
      op_a          <= '0;
      op_b          <= '0;
      bus.eng_start <= 1'b0;
      bus.rsp_valid <= '0;
      bus.rsp_data  <= '0;
      bus.rsp_err   <= 1'b0;
    end else begin
      state         <= state_nx;
      bus.eng_start <= (state_nx == LAUNCH);
      bus.rsp_valid <= rsp_fire ? (NREQ'(1) << rsp_gnt) : '0;
      bus.rsp_err   <= rsp_fire && rsp_err_nx;
      if (rsp_fire) bus.rsp_data <= rsp_val;
      if (state == IDLE && win_found) begin
        gnt  <= win;
        op_a <= in_a;
        op_b <= in_b;
      end
      if (state == RESPOND) last_grant <= gnt;
    end
  end

`ifdef GCD_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] wait_cnt;

  // Held at zero outside WAIT so every WAIT visit starts a fresh count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)               wait_cnt <= '0;
    else if (state != WAIT) wait_cnt <= '0;
    else                    wait_cnt <= wait_cnt + 1'b1;
  end

  assign timeout = (state == WAIT) && (wait_cnt == CW'(TIMEOUT - 1));
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign timeout        = 1'b0;
`endif
endmodule

// File: tb/tb_gcd_scheduler.sv
// Bench for gcd_scheduler: directed scenarios plus randomized traffic against a
// round-robin / Euclid reference model and a behavioural engine with programmable delay.
module tb_gcd_scheduler;
  localparam int NREQ = 4;
  localparam int W    = 32;
  localparam int TMO  = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gcd_scheduler_if #(.NREQ(NREQ), .W(W)) bus ();

  gcd_scheduler #(.NREQ(NREQ), .W(W), .TIMEOUT(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [NREQ-1:0] valid;
  logic [W-1:0]    a_arr [NREQ];
  logic [W-1:0]    b_arr [NREQ];
  logic            stray_done;
  logic [W-1:0]    stray_res;
  logic            model_done;
  logic [W-1:0]    model_res;
  int              eng_delay;
  bit              eng_hang;
  int              n_starts;
  int              exp_starts;
  int              n_checks;
  int              n_fail;
  int              model_last;

  assign bus.req_valid  = valid;
  assign bus.eng_done   = model_done | stray_done;
  assign bus.eng_result = stray_done ? stray_res : model_res;
  for (genvar i = 0; i < NREQ; i++) begin : g_pack
    assign bus.req_a[i*W +: W] = a_arr[i];
    assign bus.req_b[i*W +: W] = b_arr[i];
  end

  function automatic logic [W-1:0] gcd_ref(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W-1:0] t;
    while (y != '0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  function automatic int rr_pick(input logic [NREQ-1:0] v, input int last);
    for (int k = 1; k <= NREQ; k++)
      if (v[(last + k) % NREQ]) return (last + k) % NREQ;
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic new_operands(input int i);
    logic [W-1:0] g;
    case ($urandom_range(0, 5))
      0: begin a_arr[i] = '0; b_arr[i] = $urandom_range(0, 999); end
      1: begin a_arr[i] = $urandom_range(0, 999); b_arr[i] = '0; end
      2: begin a_arr[i] = $urandom; b_arr[i] = $urandom; end
      default: begin
        g        = $urandom_range(1, 500);
        a_arr[i] = g * $urandom_range(1, 60);
        b_arr[i] = g * $urandom_range(1, 60);
      end
    endcase
  endtask

  // Behavioural engine: answers gcd(eng_a, eng_b) eng_delay cycles after the start pulse.
  initial begin : engine
    int           cnt;
    bit           pend;
    logic [W-1:0] res;
    pend = 0; cnt = 0; res = '0;
    model_done = 1'b0; model_res = '0; n_starts = 0;
    forever begin
      @(negedge clk);
      model_done = 1'b0;
      if (!rst) pend = 0;
      else if (pend) begin
        if (cnt == 0) begin
          model_done = 1'b1;
          model_res  = res;
          pend       = 0;
        end else cnt--;
      end
      if (rst && bus.eng_start) begin
        n_starts++;
        if (!eng_hang) begin
          pend = 1;
          cnt  = eng_delay - 1;
          res  = gcd_ref(bus.eng_a, bus.eng_b);
        end
      end
    end
  end

  // mode 0: drop valid after accept; 1: keep same operands; 2: keep with new operands.
  task automatic transact(input int mode, input logic [NREQ-1:0] raise,
                          input logic [NREQ-1:0] drop, output int gnt);
    int           lat;
    logic [W-1:0] ea, eb, ex;
    bit           bypass;
    #1;
    lat = 0;
    while (bus.req_ready == '0 && lat < 60) begin step(); lat++; end
    gnt = rr_pick(valid, model_last);
    chk("grant", bus.req_ready, (gnt < 0) ? 64'd0 : (64'd1 << gnt));
    if (gnt < 0) return;
    ea     = a_arr[gnt];
    eb     = b_arr[gnt];
    ex     = gcd_ref(ea, eb);
    bypass = (ea == '0) || (eb == '0);
    if (!bypass) exp_starts++;
    step();
    valid |= raise;
    if (mode == 0) valid[gnt] = 1'b0;
    else if (mode == 2) new_operands(gnt);
    chk("busy", bus.busy, 1);
    chk("ready_off", bus.req_ready, 0);
    lat = 1;
    if (bypass) chk("bypass_start", bus.eng_start, 0);
    else begin
      chk("eng_start", bus.eng_start, 1);
      chk("eng_a", bus.eng_a, ea);
      chk("eng_b", bus.eng_b, eb);
      while (bus.rsp_valid == '0 && lat < eng_delay + 40) begin
        step();
        lat++;
        chk("start_pulse", bus.eng_start, 0);
        chk("eng_hold", {bus.eng_a, bus.eng_b}, {ea, eb});
      end
      chk("latency", lat, eng_delay + 2);
    end
    valid &= ~drop;
    chk("rsp_valid", bus.rsp_valid, 64'd1 << gnt);
    chk("rsp_data", bus.rsp_data, ex);
    chk("rsp_err", bus.rsp_err, 0);
    model_last = gnt;
    step();
    chk("rsp_pulse", bus.rsp_valid, 0);
    chk("rsp_hold", bus.rsp_data, ex);
    chk("idle", bus.busy, 0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int g;
    int seen;
    int lat;
    valid = '0; stray_done = 1'b0; stray_res = '0;
    eng_delay = 4; eng_hang = 0; exp_starts = 0;
    n_checks = 0; n_fail = 0; model_last = NREQ - 1;
    for (int i = 0; i < NREQ; i++) begin a_arr[i] = '0; b_arr[i] = '0; end

    // Reset state, with a requester already valid
    #2 rst = 1'b0;
    valid[1] = 1'b1; a_arr[1] = 5;
    step(); step();
    chk("rst_ready", bus.req_ready, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_data", bus.rsp_data, 0);
    chk("rst_rsp_err", bus.rsp_err, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_eng_start", bus.eng_start, 0);
    chk("rst_eng_ab", {bus.eng_a, bus.eng_b}, 0);
    valid = '0; a_arr[1] = '0;
    rst = 1'b1;
    step();

    // Single engine request
    a_arr[0] = 48; b_arr[0] = 18; eng_delay = 10; valid[0] = 1'b1;
    transact(0, '0, '0, g);
    chk("single_grant", g, 0);

    // Zero bypass
    a_arr[2] = 0; b_arr[2] = 35; valid[2] = 1'b1;
    transact(0, '0, '0, g);
    chk("bypass1_grant", g, 2);
    a_arr[2] = 0; b_arr[2] = 0; valid[2] = 1'b1;
    transact(0, '0, '0, g);
    chk("bypass2_grant", g, 2);
    chk("bypass_no_engine", n_starts, 1);

    // Stray engine done while idle
    stray_res = 77; stray_done = 1'b1;
    step();
    stray_done = 1'b0;
    step();
    chk("stray_rsp", bus.rsp_valid, 0);
    chk("stray_busy", bus.busy, 0);

    // Withdrawal: req 1 appears and leaves while busy, req 3 stays
    a_arr[0] = 30; b_arr[0] = 12; eng_delay = 6; valid[0] = 1'b1;
    a_arr[1] = 9;  b_arr[1] = 6;
    a_arr[3] = 27; b_arr[3] = 18;
    transact(0, 4'b1010, 4'b0010, g);
    chk("wd_first", g, 0);
    transact(0, '0, '0, g);
    chk("wd_grant", g, 3);

    // Reset during WAIT
    a_arr[0] = 100; b_arr[0] = 75; eng_delay = 20; valid[0] = 1'b1;
    #1;
    chk("rw_grant", bus.req_ready, 1);
    step();
    valid[0] = 1'b0;
    chk("rw_start", bus.eng_start, 1);
    exp_starts++;
    step(); step();
    rst = 1'b0;
    #1;
    chk("rw_busy", bus.busy, 0);
    chk("rw_eng_start", bus.eng_start, 0);
    chk("rw_rsp_valid", bus.rsp_valid, 0);
    chk("rw_rsp_data", bus.rsp_data, 0);
    chk("rw_eng_ab", {bus.eng_a, bus.eng_b}, 0);
    step(); step(); step();
    rst = 1'b1;
    seen = 0;
    repeat (25) begin
      step();
      if (bus.rsp_valid != '0 || bus.busy) seen++;
    end
    chk("rw_no_rsp", seen, 0);
    model_last = NREQ - 1;

    // Round-robin with all requesters continuously valid
    eng_delay = 3;
    for (int i = 0; i < NREQ; i++) begin a_arr[i] = 12; b_arr[i] = 8; end
    valid = '1;
    for (int k = 0; k < 5; k++) begin
      transact(1, '0, '0, g);
      chk("rr_order", g, k % NREQ);
    end
    valid = '0;

    // Randomized traffic
    for (int it = 0; it < 30; it++) begin
      logic [NREQ-1:0] m;
      m = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      for (int i = 0; i < NREQ; i++)
        if (m[i] && !valid[i]) begin new_operands(i); valid[i] = 1'b1; end
      eng_delay = $urandom_range(1, 12);
      transact(($urandom_range(0, 1) == 1) ? 2 : 0, '0, '0, g);
    end
    valid = '0;
    step();

    // Engine never answers
    a_arr[1] = 21; b_arr[1] = 14; valid[1] = 1'b1; eng_hang = 1;
    #1;
    chk("hang_grant", bus.req_ready, 4'b0010);
    step();
    valid[1] = 1'b0;
    exp_starts++;
    lat = 1;
`ifdef GCD_TIMEOUT_EN
    while (bus.rsp_valid == '0 && lat < TMO + 40) begin step(); lat++; end
    chk("tmo_latency", lat, TMO + 2);
    chk("tmo_rsp_valid", bus.rsp_valid, 4'b0010);
    chk("tmo_rsp_err", bus.rsp_err, 1);
    chk("tmo_rsp_data", bus.rsp_data, 0);
    step();
    chk("tmo_idle", bus.busy, 0);
    chk("tmo_pulse", bus.rsp_valid, 0);
`else
    seen = 0;
    repeat (40) begin
      step();
      if (bus.rsp_valid != '0) seen++;
    end
    chk("hang_no_rsp", seen, 0);
    chk("hang_busy", bus.busy, 1);
    stray_res = 7; stray_done = 1'b1;
    step();
    stray_done = 1'b0;
    chk("late_rsp_valid", bus.rsp_valid, 4'b0010);
    chk("late_rsp_data", bus.rsp_data, 7);
    chk("late_rsp_err", bus.rsp_err, 0);
    step();
    chk("late_idle", bus.busy, 0);
`endif
    eng_hang = 0;
    step();
    chk("start_count", n_starts, exp_starts);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
